// File: rtl/gift_effect_pkg.sv
// Shared definitions for the gift consumer: gift kind codes, the catch FSM
// state encoding and the default game-state constants.
// No ports (package).
package gift_pkg;

  typedef enum logic [2:0] {
    INC = 3'd0,
    DEC = 3'd1,
    SPU = 3'd2,
    SPD = 3'd3,
    HID = 3'd4,
    SOT = 3'd5,
    DRP = 3'd6,
    MUL = 3'd7
  } gift_kind_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    APPLY    = 2'd2,
    WAIT_CLR = 2'd3
  } gift_state_e;

  localparam int unsigned DEF_PD_W          = 64;
  localparam int unsigned DEF_SPD           = 1;
  localparam int unsigned DEF_EFFECT_FRAMES = 600;

  // Kinds that start the shared timed effect (hide / shoot / drop).
  function automatic logic is_timed(input gift_kind_e k);
    return (k == HID) || (k == SOT) || (k == DRP);
  endfunction

endpackage

// File: rtl/gift_effect_if.sv
// Gift bus between the gift generator (master) and its consumer (slave).
// Signals:
//   active - gift falling on screen
//   kind   - 3-bit gift kind code
//   x, y   - gift top-left corner in pixels
//   ack    - one-cycle pulse from the consumer when the gift is caught
interface gift_if;
  logic       active;
  logic [2:0] kind;
  logic [9:0] x;
  logic [9:0] y;
  logic       ack;

  modport master (output active, output kind, output x, output y, input ack);
  modport slave  (input active, input kind, input x, input y, output ack);
endinterface

// File: rtl/gift_effect_timer.sv
// Down-counter for the timed gift effect.
// Ports:
//   clk_i      - clock
//   rst_ni     - synchronous active-low reset (count -> 0)
//   clr_i      - synchronous clear, wins over load
//   load_i     - load load_val_i (wins over a coincident tick)
//   load_val_i - value to load
//   tick_i     - frame strobe; decrements a non-zero count
//   count_o    - remaining ticks, 0 = no effect
//   expire_o   - combinational pulse: this edge takes the count from 1 to 0
module effect_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic [W-1:0] count_o,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  // A reload on the same edge keeps the effect alive, so it is not an expiry.
  assign expire_o = tick_i && !load_i && !clr_i && (count_q == W'(1));

endmodule

// File: rtl/gift_effect.sv
// Consumer end of the gift bus: detects a paddle catch of the falling gift,
// acknowledges it exactly once and applies its effect to the game state.
// Optional build macro GIFT_MISS_EN adds parameter SCREEN_H and output
// gift_missed (pulse when a gift leaves the screen uncaught).
// Ports:
//   clock, reset   - clock, synchronous active-low reset
//   tick           - one-cycle frame strobe
//   lost           - ball lost; restores defaults and clears all effects
//   gift           - gift bus (slave side; ack is driven here)
//   paddle_x/y     - paddle top-left corner
//   paddle_w       - current paddle width
//   speed_lvl      - ball speed level 0..3
//   ball_hidden, shoot_en, drop_en - timed effect flags
//   multi_pulse    - one-cycle multi-ball request
//   effect_left    - remaining ticks of the timed effect, 0 = none
//   gift_missed    - (GIFT_MISS_EN only) uncaught gift left the screen
module gift_effect
  import gift_pkg::*;
#(
  parameter int unsigned GIFT_SZ       = 10,
  parameter int unsigned PD_H          = 10,
  parameter int unsigned PD_W_DEF      = DEF_PD_W,
  parameter int unsigned PD_W_STEP     = 16,
  parameter int unsigned PD_W_MIN      = 32,
  parameter int unsigned PD_W_MAX      = 128,
  parameter int unsigned SPD_DEF       = DEF_SPD,
  parameter int unsigned EFFECT_FRAMES = DEF_EFFECT_FRAMES
`ifdef GIFT_MISS_EN
  ,
  parameter int unsigned SCREEN_H      = 480
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        lost,
  gift_if.slave       gift,
  input  logic [9:0]  paddle_x,
  input  logic [9:0]  paddle_y,
  output logic [9:0]  paddle_w,
  output logic [1:0]  speed_lvl,
  output logic        ball_hidden,
  output logic        shoot_en,
  output logic        drop_en,
  output logic        multi_pulse,
  output logic [9:0]  effect_left
`ifdef GIFT_MISS_EN
  ,
  output logic        gift_missed
`endif
);

  gift_state_e state_q;
  logic [9:0]  paddle_w_q;
  logic [1:0]  speed_q;
  logic        hid_q;
  logic        sot_q;
  logic        drp_q;
  logic        ack_q;
  logic        multi_q;
`ifdef GIFT_MISS_EN
  logic        missed_q;
  logic        miss;
`endif

  gift_kind_e  kind_e;
  logic        overlap;
  logic        hit;
  logic        timer_load;
  logic        timer_expire;
  logic [9:0]  timer_count;

  function automatic logic [9:0] width_inc(input logic [9:0] w);
    logic [10:0] s;
    s = {1'b0, w} + 11'(PD_W_STEP);
    return (s > 11'(PD_W_MAX)) ? 10'(PD_W_MAX) : s[9:0];
  endfunction

  // Compare before subtracting so the width never underflows.
  function automatic logic [9:0] width_dec(input logic [9:0] w);
    if ({1'b0, w} < 11'(PD_W_MIN + PD_W_STEP)) begin
      return 10'(PD_W_MIN);
    end
    return w - 10'(PD_W_STEP);
  endfunction

  function automatic logic [1:0] speed_up(input logic [1:0] s);
    return (s == 2'd3) ? 2'd3 : s + 2'd1;
  endfunction

  function automatic logic [1:0] speed_down(input logic [1:0] s);
    return (s == 2'd0) ? 2'd0 : s - 2'd1;
  endfunction

  assign kind_e = gift_kind_e'(gift.kind);

  // Bounding-box overlap; every sum is 11 bits wide so nothing wraps.
  assign overlap = (({1'b0, gift.x} + 11'(GIFT_SZ)) >  {1'b0, paddle_x})
                && ({1'b0, gift.x} < ({1'b0, paddle_x} + {1'b0, paddle_w_q}))
                && (({1'b0, gift.y} + 11'(GIFT_SZ)) >= {1'b0, paddle_y})
                && ({1'b0, gift.y} <= ({1'b0, paddle_y} + 11'(PD_H)));

  assign hit        = (state_q == ARMED) && gift.active && tick && overlap;
  assign timer_load = hit && is_timed(kind_e);

`ifdef GIFT_MISS_EN
  assign miss = (state_q == ARMED) && gift.active && tick && !overlap
             && ({1'b0, gift.y} >= 11'(SCREEN_H));
`endif

  effect_timer #(
    .W (10)
  ) u_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clr_i      (lost),
    .load_i     (timer_load),
    .load_val_i (10'(EFFECT_FRAMES)),
    .tick_i     (tick),
    .count_o    (timer_count),
    .expire_o   (timer_expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      paddle_w_q <= 10'(PD_W_DEF);
      speed_q    <= 2'(SPD_DEF);
      hid_q      <= 1'b0;
      sot_q      <= 1'b0;
      drp_q      <= 1'b0;
      ack_q      <= 1'b0;
      multi_q    <= 1'b0;
`ifdef GIFT_MISS_EN
      missed_q   <= 1'b0;
`endif
    end else if (lost) begin
      // A gift still on screen must not be caught after the loss.
      state_q    <= gift.active ? WAIT_CLR : IDLE;
      paddle_w_q <= 10'(PD_W_DEF);
      speed_q    <= 2'(SPD_DEF);
      hid_q      <= 1'b0;
      sot_q      <= 1'b0;
      drp_q      <= 1'b0;
      ack_q      <= 1'b0;
      multi_q    <= 1'b0;
`ifdef GIFT_MISS_EN
      missed_q   <= 1'b0;
`endif
    end else begin
      ack_q   <= 1'b0;
      multi_q <= 1'b0;
`ifdef GIFT_MISS_EN
      missed_q <= 1'b0;
`endif
      if (timer_expire) begin
        hid_q <= 1'b0;
        sot_q <= 1'b0;
        drp_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (gift.active) state_q <= ARMED;
        end
        ARMED: begin
          if (!gift.active) begin
            state_q <= IDLE;
          end else if (hit) begin
            // Effect lands together with the ack; the APPLY state marks it.
            state_q <= APPLY;
            ack_q   <= 1'b1;
            case (kind_e)
              INC: paddle_w_q <= width_inc(paddle_w_q);
              DEC: paddle_w_q <= width_dec(paddle_w_q);
              SPU: speed_q    <= speed_up(speed_q);
              SPD: speed_q    <= speed_down(speed_q);
              HID: begin hid_q <= 1'b1; sot_q <= 1'b0; drp_q <= 1'b0; end
              SOT: begin hid_q <= 1'b0; sot_q <= 1'b1; drp_q <= 1'b0; end
              DRP: begin hid_q <= 1'b0; sot_q <= 1'b0; drp_q <= 1'b1; end
              MUL: multi_q <= 1'b1;
              default: ;
            endcase
          end
`ifdef GIFT_MISS_EN
          else if (miss) begin
            missed_q <= 1'b1;
            state_q  <= WAIT_CLR;
          end
`endif
        end
        APPLY: begin
          state_q <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!gift.active) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gift.ack    = ack_q;
  assign paddle_w    = paddle_w_q;
  assign speed_lvl   = speed_q;
  assign ball_hidden = hid_q;
  assign shoot_en    = sot_q;
  assign drop_en     = drp_q;
  assign multi_pulse = multi_q;
  assign effect_left = timer_count;
`ifdef GIFT_MISS_EN
  assign gift_missed = missed_q;
`endif

endmodule
